fifo_sync: RTL and testbench

Single-clock, parametrised FIFO for buffering print-mechanism sample and event words between capture logic and the host-side reader within one clock domain. It generalises our byte-wide register-array FIFO storage to arbitrary data width and power-of-two depth. It adds pointer and occupancy management, first-word-fall-through reads, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_sync_storage.sv | 31 +++
 rtl/fifo_sync.sv | 125 ++++++++++++
 tb/tb_fifo_sync.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers for the fifo_* family.
// No logic. Holds the pointer-width helper and the status flag bundle.
package fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_storage.sv
// Word-addressed register array: synchronous write port, asynchronous read port.
// Written data is visible on the read port from the write edge onward; never stalls.
module fifo_sync_storage #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_enable) begin
            mem[address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO with thresholds, flush and sticky errors; 1-cycle write-to-read.
// Backpressure: push refused while full (sets overflow), pop refused while empty (sets underflow).
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 8,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    write_enable,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    read_enable,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync: DATA_WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two and at least 2");
    end
    if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_sync: ALMOST_FULL_LEVEL out of range 1..DEPTH");
    end
    if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync: ALMOST_EMPTY_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_word;
    fifo_status_t          status;

    // Flags decode from registered count only, so no input reaches an output.
    always_comb begin
        status              = '0;
        status.full         = (count_q == CW'(DEPTH));
        status.almost_full  = (count_q >= CW'(ALMOST_FULL_LEVEL));
        status.empty        = (count_q == '0);
        status.almost_empty = (count_q <= CW'(ALMOST_EMPTY_LEVEL));
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    assign push = write_enable && !status.full;
    assign pop  = read_enable && !status.empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp          <= '0;
            rp          <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wp          <= '0;
            rp          <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (write_enable && status.full) begin
                overflow_q <= 1'b1;
            end
            if (read_enable && status.empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // A flush discards any word offered in the same cycle.
    fifo_sync_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PW)
    ) u_storage (
        .clk          (clk),
        .reset        (reset),
        .write_enable (push && !clear),
        .address      (wp),
        .write_data   (write_data),
        .read_address (rp),
        .read_data    (head_word)
    );

    assign read_data    = status.empty ? '0 : head_word;
    assign full         = status.full;
    assign almost_full  = status.almost_full;
    assign empty        = status.empty;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed and randomized checks of fifo_sync against a queue-based reference model.
module tb_fifo_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - 1;
    localparam int AEL   = 1;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf;
    logic          model_unf;

    fifo_sync #(
        .DATA_WIDTH         (DW),
        .DEPTH              (DEPTH),
        .ALMOST_FULL_LEVEL  (AFL),
        .ALMOST_EMPTY_LEVEL (AEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = model_q.size();
        chk({ctx, ":count"}, 32'(count), 32'(n));
        chk({ctx, ":full"}, 32'(full), 32'(n == DEPTH));
        chk({ctx, ":empty"}, 32'(empty), 32'(n == 0));
        chk({ctx, ":almost_full"}, 32'(almost_full), 32'(n >= AFL));
        chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
        chk({ctx, ":read_data"}, 32'(read_data), (n == 0) ? 32'd0 : 32'(model_q[0]));
        chk({ctx, ":overflow"}, 32'(overflow), 32'(model_ovf));
        chk({ctx, ":underflow"}, 32'(underflow), 32'(model_unf));
    endtask

    // Apply one cycle of requests, advance the model by the same rules, then compare.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic clr, input string ctx);
        int  n;
        logic do_push;
        logic do_pop;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clear        = clr;
        @(posedge clk);
        n = model_q.size();
        if (clr) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_unf = 1'b0;
        end else begin
            do_push = we && (n < DEPTH);
            do_pop  = re && (n > 0);
            if (we && n == DEPTH) model_ovf = 1'b1;
            if (re && n == 0) model_unf = 1'b1;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(wd);
        end
        #1;
        check_all(ctx);
    endtask

    initial begin
        reset        = 1'b0;
        clear        = 1'b0;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;
        model_ovf    = 1'b0;
        model_unf    = 1'b0;
        #3;
        check_all("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Fill to full, overflow, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        step(1'b1, 8'h09, 1'b0, 1'b0, "push_when_full");
        step(1'b1, 8'h0A, 1'b1, 1'b0, "full_push_pop");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", i));
        end

        // Steady-state simultaneous push/pop across pointer wrap.
        step(1'b0, 8'h00, 1'b0, 1'b1, "clear1");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "prefill4");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, $sformatf("stream%0d", i));
        end

        // Underflow and no-bypass behaviour on an empty FIFO.
        step(1'b0, 8'h00, 1'b0, 1'b1, "clear2");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pop_empty");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clear3");
        step(1'b1, 8'hA5, 1'b1, 1'b0, "empty_push_pop");

        // Clear with a concurrent push at count=5 and overflow set.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "refill");
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, "overflow_again");
        while (model_q.size() > 5) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "trim_to5");
        end
        step(1'b1, 8'h77, 1'b0, 1'b1, "clear_with_push");
        step(1'b0, 8'h00, 1'b0, 1'b0, "after_clear");

        // Asynchronous reset between edges at count=3.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, "pre_reset");
        end
        write_enable = 1'b0;
        #2;
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        #1;
        check_all("async_reset");
        #2;
        reset = 1'b1;
        step(1'b1, 8'h91, 1'b0, 1'b0, "post_reset_push");
        step(1'b1, 8'h92, 1'b0, 1'b0, "post_reset_push2");

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 99) < 3), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
